// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding and parameter-derived sizes.
package alu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Number of digit cycles needed to cover a WIDTH-bit operand
  function automatic int unsigned num_digits(input int unsigned width,
                                             input int unsigned digit);
    return width / digit;
  endfunction

  // Bits needed to count 0..n-1; never less than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry chain of full-adder cells.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  // Ripple the carry through one full-adder cell per bit
  always_comb begin
    logic [DIGIT:0] c;
    c     = '0;
    s     = '0;
    c[0]  = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    cout  = c[DIGIT];
    c_msb = c[DIGIT-1];
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice per cycle with a
// registered carry between slices, start/busy/done handshake.
module serial_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = num_digits(WIDTH, DIGIT);
  localparam int unsigned CW = cnt_width(N);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;
  logic [WIDTH-1:0] acc_shift;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .cin  (carry_q),
    .s    (dig_sum),
    .cout (dig_cout),
    .c_msb(dig_cmsb)
  );

  // New digit enters at the top; written as shift/or so DIGIT == WIDTH needs no special slice
  assign acc_shift = (acc_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));

  // Next-state logic: accept in IDLE, one digit per RUN cycle, publish on the last digit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = dig_cout;
        if (cnt_q == CW'(N - 1)) begin
          // Last digit holds the MSB, so its carries give the final flags
          sum_d   = acc_shift;
          cout_d  = dig_cout;
          ovf_d   = dig_cout ^ dig_cmsb;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // State and datapath registers, all cleared by asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed handshake/reset cases on
// the default 16/4 instance plus random sweeps over four configurations.
module tb_serial_addsub;

  localparam int unsigned NCFG = 4;
  localparam int unsigned CFG_W [NCFG] = '{16, 16, 16, 8};
  localparam int unsigned CFG_D [NCFG] = '{4, 1, 16, 2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_v [NCFG];
  logic        sub_v   [NCFG];
  logic [15:0] a_v     [NCFG];
  logic [15:0] b_v     [NCFG];
  logic [15:0] sum_v   [NCFG];
  logic        busy_v  [NCFG];
  logic        done_v  [NCFG];
  logic        cout_v  [NCFG];
  logic        ovf_v   [NCFG];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int unsigned W = CFG_W[g];
    localparam int unsigned D = CFG_D[g];
    logic [W-1:0] s_l;
    serial_addsub #(
      .WIDTH(W),
      .DIGIT(D)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start_v[g]),
      .sub  (sub_v[g]),
      .a    (a_v[g][W-1:0]),
      .b    (b_v[g][W-1:0]),
      .busy (busy_v[g]),
      .done (done_v[g]),
      .sum  (s_l),
      .cout (cout_v[g]),
      .ovf  (ovf_v[g])
    );
    assign sum_v[g] = 16'(s_l);
  end

  // Reference: {ovf, cout, sum} from plain integer arithmetic and sign rules
  function automatic logic [17:0] ref_op(input int unsigned w, input logic s,
                                         input logic [15:0] av, input logic [15:0] bv);
    logic [16:0] t;
    logic [15:0] mask, bb, r;
    logic        sa, sb, sr, co, ov;
    mask = 16'hFFFF >> (16 - w);
    bb   = s ? (~bv & mask) : bv;
    t    = {1'b0, av} + {1'b0, bb} + 17'(s);
    r    = t[15:0] & mask;
    co   = t[w];
    sa   = av[w-1];
    sb   = bv[w-1];
    sr   = r[w-1];
    ov   = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {ov, co, r};
  endfunction

  // Issue one operation and wait (bounded) for done; reports latency,
  // whether busy stayed high, and whether sum held still during RUN
  task automatic run_op(input int idx, input logic s, input logic [15:0] av,
                        input logic [15:0] bv, output int lat,
                        output logic busy_ok, output logic stable);
    logic [15:0] sum0;
    sub_v[idx]   = s;
    a_v[idx]     = av;
    b_v[idx]     = bv;
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    a_v[idx]     = 16'($urandom);
    b_v[idx]     = 16'($urandom);
    sub_v[idx]   = 1'($urandom);
    sum0    = sum_v[idx];
    busy_ok = busy_v[idx];
    stable  = 1'b1;
    lat     = 0;
    while (!done_v[idx] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!done_v[idx]) begin
        if (!busy_v[idx]) busy_ok = 1'b0;
        if (sum_v[idx] !== sum0) stable = 1'b0;
      end else if (busy_v[idx]) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      start_v[i] = 1'b0; sub_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy_v[0] !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_v[0]); else passes++;
    checks++; if (done_v[0] !== 1'b0) $display("FAIL reset_done: got %b want 0", done_v[0]); else passes++;
    checks++; if (sum_v[0] !== 16'h0000) $display("FAIL reset_sum: got %h want 0000", sum_v[0]); else passes++;
    checks++; if ({cout_v[0], ovf_v[0]} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {cout_v[0], ovf_v[0]}); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add();
    int lat; logic bok, stb;
    run_op(0, 1'b0, 16'h1234, 16'h0FFF, lat, bok, stb);
    checks++; if (sum_v[0] !== 16'h2233) $display("FAIL add_sum: got %h want 2233", sum_v[0]); else passes++;
    checks++; if ({cout_v[0], ovf_v[0]} !== 2'b00) $display("FAIL add_flags: got %b want 00", {cout_v[0], ovf_v[0]}); else passes++;
    checks++; if (lat != 4) $display("FAIL add_latency: got %0d want 4", lat); else passes++;
    checks++; if (bok !== 1'b1) $display("FAIL add_busy: got %b want 1", bok); else passes++;
    checks++; if (stb !== 1'b1) $display("FAIL add_sum_stable: got %b want 1", stb); else passes++;
  endtask

  task automatic test_add_edges();
    int lat; logic bok, stb;
    run_op(0, 1'b0, 16'hFFFF, 16'h0001, lat, bok, stb);
    checks++; if ({ovf_v[0], cout_v[0], sum_v[0]} !== {1'b0, 1'b1, 16'h0000})
      $display("FAIL add_wrap: got ovf=%b cout=%b sum=%h want 0 1 0000", ovf_v[0], cout_v[0], sum_v[0]); else passes++;
    run_op(0, 1'b0, 16'h7FFF, 16'h0001, lat, bok, stb);
    checks++; if ({ovf_v[0], cout_v[0], sum_v[0]} !== {1'b1, 1'b0, 16'h8000})
      $display("FAIL add_ovf: got ovf=%b cout=%b sum=%h want 1 0 8000", ovf_v[0], cout_v[0], sum_v[0]); else passes++;
  endtask

  task automatic test_sub();
    int lat; logic bok, stb;
    run_op(0, 1'b1, 16'h0005, 16'h0007, lat, bok, stb);
    checks++; if ({ovf_v[0], cout_v[0], sum_v[0]} !== {1'b0, 1'b0, 16'hFFFE})
      $display("FAIL sub_borrow: got ovf=%b cout=%b sum=%h want 0 0 fffe", ovf_v[0], cout_v[0], sum_v[0]); else passes++;
    run_op(0, 1'b1, 16'h8000, 16'h0001, lat, bok, stb);
    checks++; if ({ovf_v[0], cout_v[0], sum_v[0]} !== {1'b1, 1'b1, 16'h7FFF})
      $display("FAIL sub_ovf: got ovf=%b cout=%b sum=%h want 1 1 7fff", ovf_v[0], cout_v[0], sum_v[0]); else passes++;
  endtask

  // start held high: operands change every cycle, only accept-edge values count;
  // second accept lands in the done cycle, so dones are 5 cycles apart
  task automatic test_back_to_back();
    int c;
    sub_v[0] = 1'b0; a_v[0] = 16'h0001; b_v[0] = 16'h0002; start_v[0] = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy_v[0] !== 1'b1) $display("FAIL held_busy: got %b want 1", busy_v[0]); else passes++;
    for (int k = 0; k < 4; k++) begin
      a_v[0] = a_v[0] + 16'h1111;
      b_v[0] = b_v[0] + 16'h0101;
      @(posedge clk); #1;
    end
    checks++; if (done_v[0] !== 1'b1) $display("FAIL held_done: got %b want 1", done_v[0]); else passes++;
    checks++; if (sum_v[0] !== 16'h0003) $display("FAIL held_sum: got %h want 0003", sum_v[0]); else passes++;
    a_v[0] = 16'h0100; b_v[0] = 16'h0020;
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
      if (c == 1) start_v[0] = 1'b0;
    end while (!done_v[0] && c < 40);
    checks++; if (c != 5) $display("FAIL b2b_period: got %0d want 5", c); else passes++;
    checks++; if (sum_v[0] !== 16'h0120) $display("FAIL b2b_sum: got %h want 0120", sum_v[0]); else passes++;
  endtask

  task automatic test_start_busy();
    int c; logic extra;
    sub_v[0] = 1'b0; a_v[0] = 16'h0010; b_v[0] = 16'h0020; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b1; sub_v[0] = 1'b1; a_v[0] = 16'hAAAA; b_v[0] = 16'h5555;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    c = 2;
    while (!done_v[0] && c < 40) begin @(posedge clk); #1; c++; end
    checks++; if (c != 4) $display("FAIL busy_latency: got %0d want 4", c); else passes++;
    checks++; if (sum_v[0] !== 16'h0030) $display("FAIL busy_ignore_sum: got %h want 0030", sum_v[0]); else passes++;
    extra = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy_v[0] || done_v[0]) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0) $display("FAIL busy_no_queue: got %b want 0", extra); else passes++;
  endtask

  task automatic test_reset_mid();
    int lat; logic bok, stb, seen;
    run_op(0, 1'b1, 16'h8000, 16'h0001, lat, bok, stb);
    checks++; if ({ovf_v[0], cout_v[0], sum_v[0]} !== {1'b1, 1'b1, 16'h7FFF})
      $display("FAIL rst_pre: got ovf=%b cout=%b sum=%h want 1 1 7fff", ovf_v[0], cout_v[0], sum_v[0]); else passes++;
    sub_v[0] = 1'b0; a_v[0] = 16'h1111; b_v[0] = 16'h2222; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy_v[0] !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy_v[0]); else passes++;
    checks++; if (done_v[0] !== 1'b0) $display("FAIL rst_mid_done: got %b want 0", done_v[0]); else passes++;
    checks++; if (sum_v[0] !== 16'h0000) $display("FAIL rst_mid_sum: got %h want 0000", sum_v[0]); else passes++;
    checks++; if ({cout_v[0], ovf_v[0]} !== 2'b00) $display("FAIL rst_mid_flags: got %b want 00", {cout_v[0], ovf_v[0]}); else passes++;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (done_v[0]) seen = 1'b1; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (done_v[0] || busy_v[0]) seen = 1'b1; end
    checks++; if (seen !== 1'b0) $display("FAIL rst_no_done: got %b want 0", seen); else passes++;
    run_op(0, 1'b0, 16'h0001, 16'h0002, lat, bok, stb);
    checks++; if ({ovf_v[0], cout_v[0], sum_v[0]} !== {1'b0, 1'b0, 16'h0003})
      $display("FAIL rst_after: got ovf=%b cout=%b sum=%h want 0 0 0003", ovf_v[0], cout_v[0], sum_v[0]); else passes++;
  endtask

  task automatic test_sweep();
    int lat; logic bok, stb;
    logic [15:0] mask, av, bv;
    logic        s;
    logic [17:0] exp_r;
    for (int idx = 0; idx < NCFG; idx++) begin
      mask = 16'hFFFF >> (16 - CFG_W[idx]);
      for (int k = 0; k < 1000; k++) begin
        av = 16'($urandom) & mask;
        bv = 16'($urandom) & mask;
        s  = 1'($urandom);
        exp_r = ref_op(CFG_W[idx], s, av, bv);
        run_op(idx, s, av, bv, lat, bok, stb);
        checks++; if (sum_v[idx] !== exp_r[15:0])
          $display("FAIL sweep%0d_sum: %h %s %h got %h want %h", idx, av, s ? "-" : "+", bv, sum_v[idx], exp_r[15:0]); else passes++;
        checks++; if (cout_v[idx] !== exp_r[16])
          $display("FAIL sweep%0d_cout: %h %s %h got %b want %b", idx, av, s ? "-" : "+", bv, cout_v[idx], exp_r[16]); else passes++;
        checks++; if (ovf_v[idx] !== exp_r[17])
          $display("FAIL sweep%0d_ovf: %h %s %h got %b want %b", idx, av, s ? "-" : "+", bv, ovf_v[idx], exp_r[17]); else passes++;
        checks++; if (lat != int'(CFG_W[idx] / CFG_D[idx]))
          $display("FAIL sweep%0d_latency: got %0d want %0d", idx, lat, CFG_W[idx] / CFG_D[idx]); else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_add_edges();
    test_sub();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
